// File: rtl/tap_pulse_generator.sv
// Push-button front end: synchronizer, debounce, rising-edge detect and a
// tap request that is held until a game tick consumes it (one tap per press).
module tap_pulse_generator #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_in,
    input  logic       game_tick,
    output logic       tap,
    output logic       key_level,
    output logic [7:0] press_count
);

    // Synchronizer reset value is the released level so raw starts at 0.
    localparam logic             IDLE_LEVEL = ACTIVE_LOW;
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PENDING = 2'b01,
        HELD    = 2'b10
    } state_t;

    logic             sync1_r;
    logic             sync2_r;
    logic             raw_s;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             level_d_r;
    logic             rise_s;
    state_t           state_r;
    state_t           state_next_s;
    logic             count_inc_s;
    logic             tap_r;
    logic [7:0]       count_r;

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= IDLE_LEVEL;
            sync2_r <= IDLE_LEVEL;
        end else begin
            sync1_r <= key_in;
            sync2_r <= sync1_r;
        end
    end

    assign raw_s = ACTIVE_LOW ? ~sync2_r : sync2_r;

    // Debounce: a new level must persist DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= 1'b0;
        end else if (raw_s == level_r) begin
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= level_r;
        end else if (cnt_r == CNT_MAX) begin
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= raw_s;
        end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            level_r <= level_r;
        end
    end

    // Delayed copy of the debounced level for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_d_r <= 1'b0;
        end else begin
            level_d_r <= level_r;
        end
    end

    assign rise_s = level_r & ~level_d_r;

    // State register with registered tap and press counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            tap_r   <= 1'b0;
            count_r <= 8'd0;
        end else begin
            state_r <= state_next_s;
            tap_r   <= (state_next_s == PENDING);
            if (count_inc_s) begin
                count_r <= count_r + 8'd1;
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Next-state logic; a rise while PENDING is coalesced into the open request.
    always_comb begin
        state_next_s = state_r;
        count_inc_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    state_next_s = PENDING;
                    count_inc_s  = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PENDING: begin
                if (game_tick) begin
                    state_next_s = HELD;
                end else begin
                    state_next_s = PENDING;
                end
            end
            HELD: begin
                if (!level_r) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = HELD;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    assign tap         = tap_r;
    assign key_level   = level_r;
    assign press_count = count_r;

endmodule

// File: tb/tb_tap_pulse_generator.sv
// Randomized bench for tap_pulse_generator against a sample-history reference model.
module tb_tap_pulse_generator;

    localparam int D    = 4;
    localparam int NCYC = 12000;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_in;
    logic       game_tick;
    logic       tap;
    logic       key_level;
    logic [7:0] press_count;

    int n_vec  = 0;
    int n_miss = 0;

    // Model state: pressed level seen at each edge, plus request bookkeeping.
    bit p_hist [0:NCYC+8];
    bit m_level;
    bit m_level_d;
    bit m_pend;
    bit m_held;
    int m_count;
    int last_flip;

    tap_pulse_generator #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(3),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_in(key_in),
        .game_tick(game_tick),
        .tap(tap),
        .key_level(key_level),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge k with the inputs sampled at that edge.
    task automatic model_edge(input int k, input bit rst, input bit key, input bit tick);
        bit flip;
        bit rise;
        p_hist[k] = ~key;
        if (rst) begin
            p_hist[k] = 1'b0;
            if (k > 0) p_hist[k-1] = 1'b0;
            last_flip = k;
            m_level   = 1'b0;
            m_level_d = 1'b0;
            m_pend    = 1'b0;
            m_held    = 1'b0;
            m_count   = 0;
        end else begin
            // The debouncer at edge k sees the level pressed two edges earlier; it
            // flips once the last D such samples since the previous flip all differ.
            flip = (k - last_flip >= D);
            if (flip) begin
                for (int j = 0; j < D; j++) begin
                    if (p_hist[k-2-j] == m_level) flip = 1'b0;
                end
            end
            rise = m_level & ~m_level_d;
            if (m_pend) begin
                if (tick) begin
                    m_pend = 1'b0;
                    m_held = 1'b1;
                end
            end else if (m_held) begin
                if (!m_level) m_held = 1'b0;
            end else if (rise) begin
                m_pend  = 1'b1;
                m_count = (m_count + 1) % 256;
            end
            m_level_d = m_level;
            if (flip) begin
                m_level   = ~m_level;
                last_flip = k;
            end
        end
    endtask

    initial begin
        int run_left;
        int k;
        logic [7:0] exp_cnt;
        reset     = 1'b1;
        key_in    = 1'b1;
        game_tick = 1'b0;
        run_left  = 0;
        k         = 0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            k++;
            model_edge(k, reset, key_in, game_tick);
            @(negedge clk);
            exp_cnt = m_count[7:0];
            check_val("key_level", {7'd0, key_level}, {7'd0, m_level});
            check_val("tap", {7'd0, tap}, {7'd0, m_pend});
            check_val("press_count", press_count, exp_cnt);
            if (c < 3) begin
                reset = 1'b1;
            end else begin
                reset = ($urandom_range(0, 599) == 0);
            end
            if (run_left == 0) begin
                key_in   = ~key_in;
                run_left = $urandom_range(1, 14);
            end else begin
                run_left--;
            end
            game_tick = ($urandom_range(0, 5) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
